mem_bus_adapter: RTL and testbench

MEM_BUS_ADAPTER -- requirements
Module: mem_bus_adapter

---
 rtl/mem_bus_adapter.sv | 186 ++++++++++++++++++
 tb/tb_mem_bus_adapter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_adapter.sv
// CPU-to-RAM bus adapter: stalls the CPU for WAIT_STATES cycles, performs the access on a
// zero-delay word RAM, and turns partial-byte writes into a read-modify-write sequence.
module mem_bus_adapter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [3:0]  cpu_byteenable,
    input  logic [31:0] cpu_writedata,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        MERGE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);
    localparam logic       NO_WAIT   = (WAIT_STATES == 32'd0);
    localparam logic [3:0] BE_ALL    = 4'b1111;
    localparam logic [3:0] BE_NONE   = 4'b0000;

    function automatic logic [31:0] merge_bytes(input logic [31:0] new_data,
                                                input logic [31:0] old_data,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_data;
        for (int n = 0; n < 4; n++) begin
            if (be[n]) begin
                merged[8*n +: 8] = new_data[8*n +: 8];
            end else begin
                merged[8*n +: 8] = old_data[8*n +: 8];
            end
        end
        return merged;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_is_read;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_src_read;
    logic [3:0]  w_src_be;
    logic [31:0] w_src_wdata;
    logic        w_mem_read_n;
    logic        w_mem_write_n;
    logic [31:0] w_mem_wdata_n;
    logic        w_unused_addr_lsb;

    assign w_unused_addr_lsb = &cpu_address[1:0];
    assign w_accept    = (r_state == IDLE) && (cpu_read ^ cpu_write);
    // Strobes for the ACCESS cycle are decided on entry, straight from the CPU when skipping WAIT.
    assign w_src_read  = (r_state == IDLE) ? cpu_read       : r_is_read;
    assign w_src_be    = (r_state == IDLE) ? cpu_byteenable : r_be;
    assign w_src_wdata = (r_state == IDLE) ? cpu_writedata  : r_wdata;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = NO_WAIT ? ACCESS : WAIT;
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt <= 8'd1) begin
                    w_next = ACCESS;
                end else begin
                    w_next = WAIT;
                end
            end
            ACCESS: begin
                if (!r_is_read && (r_be != BE_ALL) && (r_be != BE_NONE)) begin
                    w_next = MERGE;
                end else begin
                    w_next = DONE;
                end
            end
            MERGE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM strobes for the coming cycle, so the strobe outputs come straight from flops
    always_comb begin
        w_mem_read_n  = 1'b0;
        w_mem_write_n = 1'b0;
        w_mem_wdata_n = r_mem_wdata;
        if ((w_next == ACCESS) && (r_state != ACCESS)) begin
            if (w_src_read) begin
                w_mem_read_n = 1'b1;
            end else if (w_src_be == BE_ALL) begin
                w_mem_write_n = 1'b1;
                w_mem_wdata_n = w_src_wdata;
            end else if (w_src_be != BE_NONE) begin
                w_mem_read_n = 1'b1;
            end else begin
                w_mem_read_n = 1'b0;
            end
        end else if (w_next == MERGE) begin
            w_mem_write_n = 1'b1;
        end else begin
            w_mem_write_n = 1'b0;
        end
    end

    // Request latch, wait counter, read/merge capture and strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= 8'd0;
            r_addr      <= 32'd0;
            r_is_read   <= 1'b0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_merge     <= 32'd0;
            r_rdata     <= 32'd0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_addr    <= {2'b00, cpu_address[31:2]};
                r_is_read <= cpu_read;
                r_be      <= cpu_byteenable;
                r_wdata   <= cpu_writedata;
                r_cnt     <= WAIT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if ((r_state == ACCESS) && r_is_read) begin
                r_rdata <= mem_readdata;
            end
            if ((r_state == ACCESS) && (w_next == MERGE)) begin
                r_merge <= mem_readdata;
            end
            r_mem_read  <= w_mem_read_n;
            r_mem_write <= w_mem_write_n;
            r_mem_wdata <= w_mem_wdata_n;
        end
    end

    // A simultaneous read+write in IDLE is not a request and must not stall the CPU.
    assign cpu_waitrequest = reset_n && (cpu_read || cpu_write) && (r_state != DONE) &&
                             !((r_state == IDLE) && cpu_read && cpu_write);
    assign cpu_readdata    = r_rdata;
    assign mem_address     = r_addr;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_writedata   = (r_state == MERGE) ? merge_bytes(r_wdata, r_merge, r_be) : r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Scoreboard bench for mem_bus_adapter: one instance with no wait states, one with three,
// each attached to its own behavioural zero-delay RAM.
module tb_mem_bus_adapter;

    typedef struct {
        int          lat;
        int          n_rd;
        int          n_wr;
        int          wr_cyc;
        logic [31:0] addr;
        bit          is_rd;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  reset_n;
    logic [1:0]  cpu_read;
    logic [1:0]  cpu_write;
    logic [3:0]  cpu_byteenable [2];
    logic [31:0] cpu_address    [2];
    logic [31:0] cpu_writedata  [2];
    logic [1:0]  cpu_waitrequest;
    logic [31:0] cpu_readdata   [2];
    logic [31:0] mem_address    [2];
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_writedata  [2];
    logic [31:0] mem_readdata   [2];

    logic [31:0] ram0 [16];
    logic [31:0] ram1 [16];
    logic        pl_en;
    int          pl_k;
    logic [3:0]  pl_a;
    logic [31:0] pl_d;

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   lat[2], nrd[2], nwr[2], wcyc[2], nboth[2];
    logic [31:0] saddr[2];

    always #5 clk = ~clk;

    mem_bus_adapter #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n[0]), .cpu_address(cpu_address[0]), .cpu_read(cpu_read[0]),
        .cpu_write(cpu_write[0]), .cpu_byteenable(cpu_byteenable[0]), .cpu_writedata(cpu_writedata[0]),
        .cpu_waitrequest(cpu_waitrequest[0]), .cpu_readdata(cpu_readdata[0]),
        .mem_address(mem_address[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_writedata(mem_writedata[0]), .mem_readdata(mem_readdata[0]));

    mem_bus_adapter #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]), .cpu_address(cpu_address[1]), .cpu_read(cpu_read[1]),
        .cpu_write(cpu_write[1]), .cpu_byteenable(cpu_byteenable[1]), .cpu_writedata(cpu_writedata[1]),
        .cpu_waitrequest(cpu_waitrequest[1]), .cpu_readdata(cpu_readdata[1]),
        .mem_address(mem_address[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_writedata(mem_writedata[1]), .mem_readdata(mem_readdata[1]));

    assign mem_readdata[0] = ram0[mem_address[0][3:0]];
    assign mem_readdata[1] = ram1[mem_address[1][3:0]];

    always @(posedge clk) begin
        if (pl_en) begin
            if (pl_k == 0) ram0[pl_a] <= pl_d;
            else           ram1[pl_a] <= pl_d;
        end else begin
            if (mem_write[0]) ram0[mem_address[0][3:0]] <= mem_writedata[0];
            if (mem_write[1]) ram1[mem_address[1][3:0]] <= mem_writedata[1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input int l, input int r, input int w, input int wc,
                            input logic [31:0] a, input bit isrd, input logic [31:0] rd);
        exp_t e;
        e.lat = l; e.n_rd = r; e.n_wr = w; e.wr_cyc = wc; e.addr = a; e.is_rd = isrd; e.rdata = rd;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic preload(input int k, input logic [3:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_k = k; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called #1 after a rising edge; holds the request until the DUT stops stalling.
    task automatic xfer(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input bit scramble);
        bit done;
        done = 1'b0;
        cpu_read[k] = rd; cpu_write[k] = wr; cpu_address[k] = addr;
        cpu_byteenable[k] = be; cpu_writedata[k] = wd;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!cpu_waitrequest[k]) begin
                done = 1'b1;
                break;
            end
            if (scramble && i == 1) begin
                cpu_address[k] = 32'h3C; cpu_writedata[k] = 32'hFFFFFFFF; cpu_byteenable[k] = 4'b0011;
            end
        end
        if (!done) check($sformatf("timeout%0d", k), 32'd0, 32'd1);
        @(posedge clk); #1;
        cpu_read[k] = 1'b0; cpu_write[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_waitreq"}, {31'd0, cpu_waitrequest[k]}, 32'd0);
        check({tag, "_rdata"},   cpu_readdata[k], 32'd0);
        check({tag, "_mrd"},     {31'd0, mem_read[k]}, 32'd0);
        check({tag, "_mwr"},     {31'd0, mem_write[k]}, 32'd0);
        check({tag, "_maddr"},   mem_address[k], 32'd0);
        check({tag, "_mwdata"},  mem_writedata[k], 32'd0);
    endtask

    // Monitor: tracks strobes per transfer and scores each completion against the queue.
    initial begin
        exp_t e;
        bit   have;
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; nrd[k] = 0; nwr[k] = 0; wcyc[k] = -1; nboth[k] = 0; saddr[k] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (reset_n[k] !== 1'b1 || !(cpu_read[k] ^ cpu_write[k])) begin
                    lat[k] = 0; nrd[k] = 0; nwr[k] = 0; wcyc[k] = -1; nboth[k] = 0;
                end else begin
                    if (mem_read[k])  begin nrd[k]++; saddr[k] = mem_address[k]; end
                    if (mem_write[k]) begin nwr[k]++; wcyc[k] = lat[k]; saddr[k] = mem_address[k]; end
                    if (mem_read[k] && mem_write[k]) nboth[k]++;
                    if (!cpu_waitrequest[k]) begin
                        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (!have) begin
                            checks++; failures++;
                            $display("FAIL unexpected_completion dut%0d: got completion expected none", k);
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            check($sformatf("lat%0d", k), lat[k], e.lat);
                            check($sformatf("n_rd%0d", k), nrd[k], e.n_rd);
                            check($sformatf("n_wr%0d", k), nwr[k], e.n_wr);
                            check($sformatf("both_strobes%0d", k), nboth[k], 32'd0);
                            if (e.n_rd + e.n_wr > 0) check($sformatf("mem_addr%0d", k), saddr[k], e.addr);
                            if (e.n_wr > 0) check($sformatf("wr_cycle%0d", k), wcyc[k], e.wr_cyc);
                            if (e.is_rd) check($sformatf("rdata%0d", k), cpu_readdata[k], e.rdata);
                        end
                        lat[k] = 0; nrd[k] = 0; nwr[k] = 0; wcyc[k] = -1; nboth[k] = 0;
                    end else begin
                        lat[k]++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] acc;
        reset_n = 2'b00; cpu_read = 2'b00; cpu_write = 2'b00; pl_en = 1'b0; pl_k = 0;
        pl_a = 4'd0; pl_d = 32'd0;
        for (int k = 0; k < 2; k++) begin
            cpu_address[k] = 32'd0; cpu_byteenable[k] = 4'd0; cpu_writedata[k] = 32'd0;
        end
        #12;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        @(posedge clk); #1;
        reset_n = 2'b11;

        preload(0, 4'd5, 32'hDEADBEEF);
        preload(0, 4'd1, 32'hAABBCCDD);
        preload(0, 4'd7, 32'h0BADF00D);
        preload(1, 4'd2, 32'h00000000);
        preload(1, 4'd3, 32'hCAFEF00D);

        // No wait states: read, read with low address bits set, partial write, empty write
        push_exp(0, 2, 1, 0, 0, 32'd5, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b1, 1'b0, 32'h14, 4'b0000, 32'd0, 1'b0);
        push_exp(0, 2, 1, 0, 0, 32'd5, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b1, 1'b0, 32'h17, 4'b0000, 32'd0, 1'b0);
        push_exp(0, 3, 1, 1, 2, 32'd1, 1'b0, 32'd0);
        xfer(0, 1'b0, 1'b1, 32'h4, 4'b0101, 32'h11223344, 1'b0);
        check("ram0_word1_merged", ram0[1], 32'hAA22CC44);
        check("rdata_held", cpu_readdata[0], 32'hDEADBEEF);
        push_exp(0, 2, 0, 0, 0, 32'd0, 1'b0, 32'd0);
        xfer(0, 1'b0, 1'b1, 32'h1C, 4'b0000, 32'hFFFFFFFF, 1'b0);
        check("ram0_word7_untouched", ram0[7], 32'h0BADF00D);

        // Read and write together: ignored, no stall, no strobes
        cpu_read[0] = 1'b1; cpu_write[0] = 1'b1; cpu_address[0] = 32'h14; cpu_byteenable[0] = 4'b1111;
        acc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc = acc | {29'd0, cpu_waitrequest[0], mem_read[0], mem_write[0]};
        end
        @(posedge clk); #1;
        cpu_read[0] = 1'b0; cpu_write[0] = 1'b0;
        check("both_high_quiet", acc, 32'd0);
        check("both_high_ram_word5", ram0[5], 32'hDEADBEEF);
        @(posedge clk); #1;
        push_exp(0, 2, 1, 0, 0, 32'd5, 1'b1, 32'hDEADBEEF);
        xfer(0, 1'b1, 1'b0, 32'h14, 4'b0000, 32'd0, 1'b0);

        // Three wait states: full write with inputs changed after the latch, read, partial, empty
        push_exp(1, 5, 0, 1, 4, 32'd2, 1'b0, 32'd0);
        xfer(1, 1'b0, 1'b1, 32'h8, 4'b1111, 32'h12345678, 1'b1);
        check("ram1_word2_full", ram1[2], 32'h12345678);
        check("ram1_word15_untouched", ram1[15] === 32'hFFFFFFFF ? 32'd1 : 32'd0, 32'd0);
        push_exp(1, 5, 1, 0, 0, 32'd2, 1'b1, 32'h12345678);
        xfer(1, 1'b1, 1'b0, 32'h8, 4'b0000, 32'd0, 1'b0);
        push_exp(1, 6, 1, 1, 5, 32'd2, 1'b0, 32'd0);
        xfer(1, 1'b0, 1'b1, 32'hB, 4'b1000, 32'hEE000000, 1'b0);
        check("ram1_word2_partial", ram1[2], 32'hEE345678);
        push_exp(1, 5, 0, 0, 0, 32'd0, 1'b0, 32'd0);
        xfer(1, 1'b0, 1'b1, 32'hC, 4'b0000, 32'h55555555, 1'b0);
        check("ram1_word3_untouched", ram1[3], 32'hCAFEF00D);

        // Reset pulse while in MERGE aborts the write
        preload(0, 4'd4, 32'h01020304);
        cpu_write[0] = 1'b1; cpu_address[0] = 32'h10; cpu_byteenable[0] = 4'b0011;
        cpu_writedata[0] = 32'hFFFFFFFF;
        @(posedge clk);
        @(posedge clk); #1;
        check("merge_reached", {31'd0, mem_write[0]}, 32'd1);
        reset_n[0] = 1'b0;
        #1;
        check_zero(0, "abort");
        cpu_write[0] = 1'b0;
        @(negedge clk);
        reset_n[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_ram_word4", ram0[4], 32'h01020304);

        check("scoreboard_drained", q0.size() + q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
